// File: rtl/cpu_bus_master.sv
// ============================================================================
// Module   : cpu_bus_master
// Brief    : CPU-side master for bus 1 (A1/D1/C1). It sends a request to the
//            cache in two cycles, turns the bus around and returns the response.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_bus_master #(
    parameter int ADDR_HI_BITS   = 15,
    parameter int ADDR_LO_BITS   = 4,
    parameter int DATA1_BUS_SIZE = 16,
    parameter int CTR1_BUS_SIZE  = 3,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                                 CLK,
    input  logic                                 RESET,
    input  logic                                 req_valid,
    output logic                                 req_ready,
    input  logic [CTR1_BUS_SIZE-1:0]             req_cmd,
    input  logic [ADDR_HI_BITS+ADDR_LO_BITS-1:0] req_addr,
    input  logic [2*DATA1_BUS_SIZE-1:0]          req_wdata,
    output logic                                 rsp_valid,
    output logic [2*DATA1_BUS_SIZE-1:0]          rsp_data,
    output logic                                 rsp_err,
    output logic                                 busy,
    inout  wire  [ADDR_HI_BITS-1:0]              A1,
    inout  wire  [DATA1_BUS_SIZE-1:0]            D1,
    inout  wire  [CTR1_BUS_SIZE-1:0]             C1
);

    localparam int c_dw    = DATA1_BUS_SIZE;
    localparam int c_aw    = ADDR_HI_BITS + ADDR_LO_BITS;
    localparam int c_cnt_w = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [c_cnt_w-1:0]       c_cnt_last = c_cnt_w'(TIMEOUT_CYCLES - 1);
    localparam logic [CTR1_BUS_SIZE-1:0] c_nop      = CTR1_BUS_SIZE'(0);
    localparam logic [CTR1_BUS_SIZE-1:0] c_read8    = CTR1_BUS_SIZE'(1);
    localparam logic [CTR1_BUS_SIZE-1:0] c_read16   = CTR1_BUS_SIZE'(2);
    localparam logic [CTR1_BUS_SIZE-1:0] c_read32   = CTR1_BUS_SIZE'(3);
    localparam logic [CTR1_BUS_SIZE-1:0] c_write8   = CTR1_BUS_SIZE'(5);
    localparam logic [CTR1_BUS_SIZE-1:0] c_write16  = CTR1_BUS_SIZE'(6);
    localparam logic [CTR1_BUS_SIZE-1:0] c_write32  = CTR1_BUS_SIZE'(7);
    localparam logic [CTR1_BUS_SIZE-1:0] c_response = CTR1_BUS_SIZE'(7);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SEND1 = 3'd1,
        S_SEND2 = 3'd2,
        S_TURN  = 3'd3,
        S_WAIT  = 3'd4,
        S_RECV2 = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t                    r_state;
    state_t                    w_next;
    logic [CTR1_BUS_SIZE-1:0]  r_cmd;
    logic [c_aw-1:0]           r_addr;
    logic [2*c_dw-1:0]         r_wdata;
    logic [2*c_dw-1:0]         r_buf;
    logic [2*c_dw-1:0]         w_buf_next;
    logic [c_cnt_w-1:0]        r_cnt;
    logic [2*c_dw-1:0]         r_rsp_data;
    logic                      r_rsp_err;
    logic                      w_done_err;
    logic                      w_is_write;
    logic                      w_own_ac;
    logic                      w_own_d;
    logic [ADDR_HI_BITS-1:0]   w_a1;
    logic [c_dw-1:0]           w_d1;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state    <= S_IDLE;
            r_cmd      <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_buf      <= '0;
            r_cnt      <= '0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_buf   <= w_buf_next;
            if (r_state == S_IDLE && req_valid) begin
                r_cmd   <= req_cmd;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
            end
            r_cnt <= (r_state == S_WAIT) ? r_cnt + c_cnt_w'(1) : '0;
            // Result registers only move when entering DONE, so they hold between responses.
            if (w_next == S_DONE) begin
                r_rsp_data <= w_buf_next;
                r_rsp_err  <= w_done_err;
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        w_buf_next = r_buf;
        w_done_err = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_buf_next = '0;
                if (req_valid) begin
                    if (req_cmd == c_nop) begin
                        w_next     = S_DONE;
                        w_done_err = 1'b1;
                    end else begin
                        w_next = S_SEND1;
                    end
                end
            end
            S_SEND1: w_next = S_SEND2;
            S_SEND2: w_next = S_TURN;
            S_TURN:  w_next = S_WAIT;
            S_WAIT: begin
                // A floating or unknown C1 compares false and reads as no response.
                if (C1 == c_response) begin
                    w_next = S_DONE;
                    case (r_cmd)
                        c_read8:  w_buf_next = {{(2*c_dw-8){1'b0}}, D1[7:0]};
                        c_read16: w_buf_next = {{c_dw{1'b0}}, D1};
                        c_read32: begin
                            w_buf_next[c_dw-1:0] = D1;
                            w_next               = S_RECV2;
                        end
                        default: ;
                    endcase
                end else if (r_cnt == c_cnt_last) begin
                    w_next     = S_DONE;
                    w_done_err = 1'b1;
                end
            end
            S_RECV2: begin
                w_buf_next[2*c_dw-1:c_dw] = D1;
                w_next                    = S_DONE;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    assign w_is_write = (r_cmd == c_write8) || (r_cmd == c_write16) || (r_cmd == c_write32);
    assign w_own_ac   = (r_state == S_SEND1) || (r_state == S_SEND2);
    assign w_own_d    = ((r_state == S_SEND1) && w_is_write) ||
                        ((r_state == S_SEND2) && (r_cmd == c_write32));
    assign w_a1       = (r_state == S_SEND1) ? r_addr[c_aw-1:ADDR_LO_BITS]
                                             : ADDR_HI_BITS'(r_addr[ADDR_LO_BITS-1:0]);
    assign w_d1       = (r_state == S_SEND1) ? r_wdata[c_dw-1:0] : r_wdata[2*c_dw-1:c_dw];

    assign A1 = w_own_ac ? w_a1  : 'z;
    assign C1 = w_own_ac ? r_cmd : 'z;
    assign D1 = w_own_d  ? w_d1  : 'z;

    assign req_ready = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign rsp_valid = (r_state == S_DONE);
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;

endmodule

`default_nettype wire
